// File: rtl/fetch_queue.sv
// Instruction fetch queue: a circular buffer of {instr, pc+4} between a combinational imem and IF/ID.
// Optional same-cycle empty-queue bypass is enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [31:0]              imem_addr,
    input  logic [31:0]              imem_rdata,
    input  logic                     deq_en,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic                     out_valid,
    output logic [31:0]              out_instr,
    output logic [31:0]              out_pc4,
    output logic [$clog2(DEPTH):0]   fq_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [31:0]     fetch_pc4;
    logic            empty;
    logic            full;
    logic            pop;
    logic            advance;
    logic            push;
    logic            bypass_take;
    entry_t          head;

    assign fetch_pc4 = imem_addr + 32'd4;
    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign head      = mem[rd_ptr];

    // A pop frees a slot in the same cycle, so a full queue keeps fetching while draining.
    assign pop     = deq_en && !empty && !redirect;
    assign advance = !redirect && (!full || pop);

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass_active;

    assign bypass_active = empty && !redirect && !reset;
    assign bypass_take   = bypass_active && deq_en;

    always_comb begin
        out_valid = 1'b0;
        out_instr = 32'h0;
        out_pc4   = 32'h0;
        if (!empty) begin
            out_valid = 1'b1;
            out_instr = head.instr;
            out_pc4   = head.pc4;
        end else if (bypass_active) begin
            out_valid = 1'b1;
            out_instr = imem_rdata;
            out_pc4   = fetch_pc4;
        end
    end
`else
    assign bypass_take = 1'b0;

    // NOTE: every variable driven in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        out_valid = 1'b0;
        out_instr = 32'h0;
        out_pc4   = 32'h0;
        if (!empty) begin
            out_valid = 1'b1;
            out_instr = head.instr;
            out_pc4   = head.pc4;
        end
    end
`endif

    // A bypassed instruction is consumed directly, so the fetch advances without a write.
    assign push = advance && !bypass_take;

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            imem_addr <= RESET_PC;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
        end else if (redirect) begin
            imem_addr <= redirect_pc;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
        end else begin
            if (advance) imem_addr <= fetch_pc4;
            if (push)    wr_ptr    <= wr_ptr + AW'(1);
            if (pop)     rd_ptr    <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; count/pointers qualify every entry, so stale data is never visible.
    always_ff @(posedge clk) begin
        if (push && !reset) mem[wr_ptr] <= '{instr: imem_rdata, pc4: fetch_pc4};
    end

    assign fq_count = count;

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
- REQ-001 SHALL have parameter DEPTH, default 4: number of queue entries; a power of two, minimum 2.
- REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
- REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
- REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
- REQ-005 SHALL have port imem_addr  output  32  current fetch PC, driven to the combinational instruction memory.
- REQ-006 SHALL have port imem_rdata  input  32  instruction at imem_addr, valid in the same cycle.
- REQ-007 SHALL have port deq_en  input  1  consumer (IF/ID write enable) accepts the head entry this cycle.
- REQ-008 SHALL have port redirect  input  1  flush the queue and restart fetch (jump, bne taken, jr).
- REQ-009 SHALL have port redirect_pc  input  32  new fetch PC when redirect=1.
- REQ-010 SHALL have port out_valid  output  1  head entry present.
- REQ-011 SHALL have port out_instr  output  32  head instruction; 32'h0 when out_valid=0.
- REQ-012 SHALL have port out_pc4  output  32  head PC+4; 32'h0 when out_valid=0.
- REQ-013 SHALL have port fq_count  output  clog2(DEPTH)+1  number of occupied entries.

Function
- REQ-014 SHALL store entries {instr, pc+4} in a circular buffer with wrapping read/write pointers.
- REQ-015 SHALL enqueue {imem_rdata, imem_addr+4} and advance imem_addr by 4 in every cycle where redirect=0 and (count<DEPTH or a dequeue occurs in that cycle).
- REQ-016 SHALL dequeue the head in every cycle where deq_en=1, out_valid=1 and redirect=0; deq_en with out_valid=0 SHALL be ignored.
- REQ-017 SHALL leave count unchanged on a simultaneous enqueue and dequeue, including when full; entries SHALL leave in enqueue order.
- REQ-018 SHALL, when full and not dequeuing, hold imem_addr and perform no write.
- REQ-019 SHALL, on redirect=1, next cycle present count=0, out_valid=0 and imem_addr=redirect_pc; redirect SHALL override any enqueue and dequeue in that cycle.
- REQ-020 SHALL present out_* combinationally from the head entry (one-cycle fetch-to-output latency without bypass).
- REQ-021 SHALL compute PC arithmetic modulo 2^32 (0xFFFF_FFFC + 4 wraps to 0).

Reset
- REQ-022 SHALL, while reset=1 at a clock edge, set imem_addr=RESET_PC, pointers=0, count=0, out_valid=0, out_instr=0, out_pc4=0; reset SHALL override redirect and deq_en.
- REQ-023 SHALL discard all queued entries on reset asserted mid-operation.

Configuration
- REQ-024 SHALL, with FETCH_QUEUE_BYPASS_EN defined, drive out_valid=1, out_instr=imem_rdata, out_pc4=imem_addr+4 combinationally when count=0 and redirect=0; with deq_en=1 in that cycle the instruction SHALL be consumed without being written, and imem_addr SHALL advance by 4.
- REQ-025 SHALL, without FETCH_QUEUE_BYPASS_EN, show out_valid=0 whenever count=0, and include no bypass logic.

Verification
- REQ-026 Reset 2 cycles, then deq_en=0 -> imem_addr=0x0, out_valid=0; after 4 cycles fq_count=4, imem_addr=0x10, further cycles change nothing.
- REQ-027 Full queue, deq_en=1 for 3 cycles -> fq_count stays 4, out_pc4 sequence 0x4,0x8,0xC, imem_addr reaches 0x1C.
- REQ-028 fq_count=3 with redirect=1, redirect_pc=0x40, deq_en=1 -> next cycle fq_count=0, out_valid=0, imem_addr=0x40; one cycle later out_pc4=0x44.
- REQ-029 Pointer wrap: deq_en=1 continuously for 10 cycles after fill -> out_pc4 strictly increments by 4, no drop or duplicate across pointer wrap.
- REQ-030 reset=1 asserted while fq_count=2 and redirect=1 -> next cycle imem_addr=RESET_PC, fq_count=0.
- REQ-031 FETCH_QUEUE_BYPASS_EN defined, empty queue, imem_rdata=0x2002_0005 at imem_addr=0x0, deq_en=1 -> same cycle out_valid=1, out_instr=0x2002_0005, out_pc4=0x4; next cycle fq_count=0, imem_addr=0x4.
